// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared types and constants for the two-master Wishbone arbiter slice.
//   DEFAULT_WIDTH : default address/data width of every bus
//   SEL_W         : number of byte lanes on a bus
//   owner_t       : registered bus owner (IDLE / OWN_A / OWN_B)
//   grant_t       : effective grant derived from owner and requests
package ram_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int SEL_W         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   One Wishbone-classic bus (cycle, write enable, byte lanes, address,
//   write data, ack, read data).
//   master modport : drives cyc/we/sel/adr/dat, receives ack/rdt
//   slave modport  : receives cyc/we/sel/adr/dat, drives ack/rdt
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             cyc;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] dat;
  logic             ack;
  logic [WIDTH-1:0] rdt;

  modport master (output cyc, we, sel, adr, dat, input ack, rdt);
  modport slave  (input cyc, we, sel, adr, dat, output ack, rdt);

endinterface

// File: rtl/ram_arbiter_sp_ram.sv
// sp_ram
//   Single-port word RAM with byte-lane writes and registered read data.
//   Parameters: WORDS (depth in 32-bit words), WIDTH (address width)
//   ck    : clock, rising edge
//   rst_n : asynchronous active-low reset of the read data register only
//   cyc   : access request
//   we    : write enable
//   sel   : byte lane enables for writes
//   addr  : byte address, word index taken from addr[$clog2(WORDS)+1:2]
//   wdata : write data
//   rdata : registered read data, zero unless the last edge saw a read
module sp_ram
  import ram_arbiter_pkg::*;
#(
  parameter int WORDS = 512,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             cyc,
  input  logic             we,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int AW = $clog2(WORDS);

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  assign idx = addr[AW+1:2];

  // Byte-offset bits and address bits above the array are ignored.
  assign unused_addr_bits = ^{addr[WIDTH-1:AW+2], addr[1:0]};

  // Storage has no reset so it maps onto plain RAM macros.
  always_ff @(posedge ck) begin
    if (cyc && we) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (sel[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read data is forced to zero outside reads so an idle bus reads as zero.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= (cyc && !we) ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-master Wishbone-classic arbiter onto one downstream port. Master A
//   has fixed priority when the bus is free; a cycle that already owns the
//   bus always completes. The arbiter adds no wait states: requests, ack and
//   read data pass through combinationally to/from the granted master.
//   Parameter: WIDTH (address/data width of all buses)
//   wb_clk   : clock, rising edge
//   wb_rst_n : asynchronous active-low reset
//   a, b     : upstream buses (slave modports, one per master)
//   x        : downstream bus (master modport)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  ram_arbiter_if.slave  a,
  ram_arbiter_if.slave  b,
  ram_arbiter_if.master x
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  owner_t owner;
  grant_t grant;

  // A free bus goes to A first; once owned, the owner keeps the grant until
  // the slave acks, which is what prevents preemption of a B cycle.
  always_comb begin
    grant = GNT_NONE;
    case (owner)
      OWN_A:   grant = GNT_A;
      OWN_B:   grant = GNT_B;
      default: begin
        if (a.cyc) begin
          grant = GNT_A;
        end else if (b.cyc) begin
          grant = GNT_B;
        end
      end
    endcase
  end

  // Ownership is latched on the first cycle of a request so the grant holds
  // even if the other master raises cyc mid-cycle. A single-cycle ack from
  // IDLE never latches ownership.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      owner <= IDLE;
    end else if (x.ack) begin
      owner <= IDLE;
    end else if (owner == IDLE) begin
      if (grant == GNT_A) begin
        owner <= OWN_A;
      end else if (grant == GNT_B) begin
        owner <= OWN_B;
      end
    end
  end

  // Downstream mux; an ungranted bus is driven to all zeros.
  always_comb begin
    x.cyc = 1'b0;
    x.we  = 1'b0;
    x.sel = '0;
    x.adr = ZERO;
    x.dat = ZERO;
    case (grant)
      GNT_A: begin
        x.cyc = a.cyc;
        x.we  = a.we;
        x.sel = a.sel;
        x.adr = a.adr;
        x.dat = a.dat;
      end
      GNT_B: begin
        x.cyc = b.cyc;
        x.we  = b.we;
        x.sel = b.sel;
        x.adr = b.adr;
        x.dat = b.dat;
      end
      default: ;
    endcase
  end

  assign a.ack = x.ack && (grant == GNT_A);
  assign b.ack = x.ack && (grant == GNT_B);
  assign a.rdt = (grant == GNT_A) ? x.rdt : ZERO;
  assign b.rdt = (grant == GNT_B) ? x.rdt : ZERO;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Arbiter plus sp_ram plus a one-cycle ack generator. Two master processes
//   issue transactions; a transaction-level reference model (bus occupied for
//   two cycles per transfer, free bus goes to A first, transfers never
//   interrupted, word memory updated in service order) turns issued
//   transactions into expected acks that a monitor compares against the DUT.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  typedef struct {
    bit          is_b;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  typedef struct {
    bit          is_b;
    int          ack_cycle;
    logic [31:0] rdt;
  } exp_t;

  logic wb_clk   = 1'b0;
  logic wb_rst_n = 1'b0;

  always #5 wb_clk = ~wb_clk;

  ram_arbiter_if #(.WIDTH(32)) a_bus ();
  ram_arbiter_if #(.WIDTH(32)) b_bus ();
  ram_arbiter_if #(.WIDTH(32)) x_bus ();

  ram_arbiter #(.WIDTH(32)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .a        (a_bus),
    .b        (b_bus),
    .x        (x_bus)
  );

  logic        x_ack_r;
  logic [31:0] ram_rdata;

  sp_ram #(.WORDS(512), .WIDTH(32)) ram (
    .ck    (wb_clk),
    .rst_n (wb_rst_n),
    .cyc   (x_bus.cyc),
    .we    (x_bus.we),
    .sel   (x_bus.sel),
    .addr  (x_bus.adr),
    .wdata (x_bus.dat),
    .rdata (ram_rdata)
  );

  // Slave wrapper: ack one cycle after cyc is first seen.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) x_ack_r <= 1'b0;
    else           x_ack_r <= x_bus.cyc & ~x_ack_r;
  end

  assign x_bus.ack = x_ack_r;
  assign x_bus.rdt = ram_rdata;

  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  txn_t a_q[$];
  txn_t b_q[$];
  exp_t exp_q[$];
  logic [31:0] ref_mem [int];
  txn_t cur;
  int   cur_until = -1;

  always @(posedge wb_clk) cycle++;

  initial begin
    a_bus.cyc = 0; a_bus.we = 0; a_bus.sel = 0; a_bus.adr = 0; a_bus.dat = 0;
    b_bus.cyc = 0; b_bus.we = 0; b_bus.sel = 0; b_bus.adr = 0; b_bus.dat = 0;
  end

  task automatic check_output(input string name, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] adr);
    int key = int'(adr[10:2]);
    if (ref_mem.exists(key)) return ref_mem[key];
    return 'x;
  endfunction

  task automatic ref_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    int key = int'(adr[10:2]);
    logic [31:0] w = ref_read(adr);
    for (int i = 0; i < 4; i++) if (sel[i]) w[i*8 +: 8] = dat[i*8 +: 8];
    ref_mem[key] = w;
  endtask

  // Reference model: start a transfer on a free bus (A before B), expect ack
  // on the following cycle, and the bus is free again the cycle after that.
  task automatic model_start(input txn_t t);
    exp_t e;
    e.is_b      = t.is_b;
    e.ack_cycle = cycle + 1;
    e.rdt       = t.we ? 32'h0 : ref_read(t.adr);
    if (t.we) ref_write(t.adr, t.sel, t.dat);
    exp_q.push_back(e);
    cur       = t;
    cur_until = cycle + 1;
  endtask

  // Monitor: model step, bus mirror check, ack scoreboard, idle checks.
  initial begin
    exp_t e;
    bit   a_owns, b_owns;
    forever begin
      @(negedge wb_clk);
      if (mon_en) begin
        if (cycle > cur_until) begin
          if (a_q.size() > 0)      model_start(a_q.pop_front());
          else if (b_q.size() > 0) model_start(b_q.pop_front());
        end
        if (cycle <= cur_until)
          check_output("x_mirror", {x_bus.cyc, x_bus.we, x_bus.sel, x_bus.adr, x_bus.dat},
                       {1'b1, cur.we, cur.sel, cur.adr, cur.dat});
        else
          check_output("x_idle", {x_bus.cyc, x_bus.we, x_bus.sel, x_bus.adr, x_bus.dat}, 72'h0);
        if (a_bus.ack && b_bus.ack) begin
          check_output("dual_ack", 2'b11, 2'b01);
        end else if (a_bus.ack || b_bus.ack) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_ack", {a_bus.ack, b_bus.ack}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            check_output("ack_master", b_bus.ack, e.is_b);
            check_output("ack_cycle", cycle, e.ack_cycle);
            check_output("ack_rdt", b_bus.ack ? b_bus.rdt : a_bus.rdt, e.rdt);
          end
        end else if (exp_q.size() > 0 && exp_q[0].ack_cycle < cycle) begin
          e = exp_q.pop_front();
          check_output("missing_ack", cycle, e.ack_cycle);
        end
        a_owns = (cycle <= cur_until) && !cur.is_b;
        b_owns = (cycle <= cur_until) && cur.is_b;
        if (!a_owns) check_output("a_idle", {a_bus.ack, a_bus.rdt}, 72'h0);
        if (!b_owns) check_output("b_idle", {b_bus.ack, b_bus.rdt}, 72'h0);
      end
    end
  end

  // One master transaction: issue, hold until ack, drop on the next edge.
  task automatic apply_stimulus(input bit is_b, input logic we, input logic [3:0] sel,
                                input logic [31:0] adr, input logic [31:0] dat,
                                input int pre_delay, output logic [31:0] rdt);
    txn_t t;
    bit   acked = 0;
    t = '{is_b, we, sel, adr, dat};
    rdt = '0;
    repeat (pre_delay) @(posedge wb_clk);
    @(posedge wb_clk); #1;
    if (is_b) begin
      b_bus.we = we; b_bus.sel = sel; b_bus.adr = adr; b_bus.dat = dat; b_bus.cyc = 1;
      b_q.push_back(t);
    end else begin
      a_bus.we = we; a_bus.sel = sel; a_bus.adr = adr; a_bus.dat = dat; a_bus.cyc = 1;
      a_q.push_back(t);
    end
    for (int k = 0; k < 40 && !acked; k++) begin
      @(negedge wb_clk);
      if (is_b ? b_bus.ack : a_bus.ack) begin
        acked = 1;
        rdt = is_b ? b_bus.rdt : a_bus.rdt;
      end
    end
    if (!acked) begin
      total++;
      bad++;
      $display("[TB] FAIL ack_timeout: master %s got no ack within 40 cycles", is_b ? "B" : "A");
    end
    @(posedge wb_clk); #1;
    if (is_b) begin
      b_bus.cyc = 0; b_bus.we = 0; b_bus.sel = 0; b_bus.adr = 0; b_bus.dat = 0;
    end else begin
      a_bus.cyc = 0; a_bus.we = 0; a_bus.sel = 0; a_bus.adr = 0; a_bus.dat = 0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] vals [4];
    int          ia, ib, da, db;
    logic        wa, wb;
    logic [3:0]  sa, sb;

    vals[0] = 32'h00000000; vals[1] = 32'h11111111;
    vals[2] = 32'h22222222; vals[3] = 32'h44444444;

    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    check_output("reset_x", {x_bus.cyc, x_bus.we, x_bus.sel, x_bus.adr, x_bus.dat}, 72'h0);
    check_output("reset_ack", {a_bus.ack, b_bus.ack, x_bus.ack}, 72'h0);
    check_output("reset_rdt", {a_bus.rdt, b_bus.rdt}, 72'h0);
    @(posedge wb_clk); #1;
    wb_rst_n = 1;
    mon_en   = 1;

    $display("[TB] sequential writes and reads");
    apply_stimulus(0, 1, 4'hf, 32'h20, 32'h12343456, 0, ra);
    apply_stimulus(1, 1, 4'hf, 32'h10, 32'hcafecafe, 0, rb);
    apply_stimulus(0, 0, 4'hf, 32'h20, 32'h0, 0, ra);
    check_output("rd_a_20", ra, 32'h12343456);
    apply_stimulus(1, 0, 4'hf, 32'h10, 32'h0, 0, rb);
    check_output("rd_b_10", rb, 32'hcafecafe);

    $display("[TB] simultaneous writes");
    fork
      apply_stimulus(0, 1, 4'hf, 32'h00, 32'h12341234, 0, ra);
      apply_stimulus(1, 1, 4'hf, 32'h04, 32'habcdabcd, 0, rb);
    join
    fork
      apply_stimulus(0, 0, 4'hf, 32'h04, 32'h0, 0, ra);
      apply_stimulus(1, 0, 4'hf, 32'h00, 32'h0, 0, rb);
    join
    check_output("rd_a_04", ra, 32'habcdabcd);
    check_output("rd_b_00", rb, 32'h12341234);
    fork
      apply_stimulus(0, 1, 4'hf, 32'h08, 32'h12341234, 0, ra);
      apply_stimulus(1, 1, 4'hf, 32'h08, 32'habcdabcd, 0, rb);
    join
    apply_stimulus(0, 0, 4'hf, 32'h08, 32'h0, 0, ra);
    check_output("rd_same_08", ra, 32'habcdabcd);

    $display("[TB] B ahead of A, no preemption");
    for (int d = 1; d <= 2; d++) begin
      fork
        apply_stimulus(0, 1, 4'hf, 32'h18, 32'h55550000 | d, d, ra);
        apply_stimulus(1, 1, 4'hf, 32'h1c, 32'h66660000 | d, 0, rb);
      join
      fork
        apply_stimulus(0, 0, 4'hf, 32'h1c, 32'h0, 0, ra);
        apply_stimulus(1, 0, 4'hf, 32'h18, 32'h0, 0, rb);
      join
      check_output("rd_b_first", ra, 32'h66660000 | d);
      check_output("rd_a_later", rb, 32'h55550000 | d);
    end

    $display("[TB] overlapping reads");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 4'hf, 32'h30 + 4 * i, vals[i], 0, ra);
    for (int off = -2; off <= 2; off++) begin
      ia = (off + 2) % 4;
      ib = (off + 3) % 4;
      fork
        apply_stimulus(0, 0, 4'hf, 32'h30 + 4 * ia, 32'h0, (off < 0) ? -off : 0, ra);
        apply_stimulus(1, 0, 4'hf, 32'h30 + 4 * ib, 32'h0, (off > 0) ? off : 0, rb);
      join
      check_output("ovl_rd_a", ra, vals[ia]);
      check_output("ovl_rd_b", rb, vals[ib]);
    end

    $display("[TB] read/write conflict");
    apply_stimulus(1, 1, 4'hf, 32'h14, 32'hfaceface, 0, rb);
    fork
      apply_stimulus(0, 0, 4'hf, 32'h14, 32'h0, 0, ra);
      apply_stimulus(1, 1, 4'hf, 32'h14, 32'h12345678, 0, rb);
    join
    check_output("conflict_old", ra, 32'hfaceface);
    apply_stimulus(0, 0, 4'hf, 32'h14, 32'h0, 0, ra);
    check_output("conflict_new", ra, 32'h12345678);

    $display("[TB] byte lanes");
    apply_stimulus(0, 1, 4'b0001, 32'h24, 32'h000000ab, 0, ra);
    apply_stimulus(0, 1, 4'b0010, 32'h24, 32'h0000cd00, 0, ra);
    apply_stimulus(0, 1, 4'b0100, 32'h24, 32'h00fe0000, 0, ra);
    apply_stimulus(0, 1, 4'b1000, 32'h24, 32'hca000000, 0, ra);
    apply_stimulus(1, 0, 4'hf, 32'h24, 32'h0, 0, rb);
    check_output("bytes", rb, 32'hcafecdab);
    apply_stimulus(1, 1, 4'b0011, 32'h28, 32'h00001234, 0, rb);
    apply_stimulus(1, 1, 4'b1100, 32'h28, 32'habcd0000, 0, rb);
    apply_stimulus(0, 0, 4'hf, 32'h28, 32'h0, 0, ra);
    check_output("halfwords", ra, 32'habcd1234);

    $display("[TB] random traffic");
    for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 4'hf, 32'h40 + 4 * i, $urandom, 0, ra);
    for (int n = 0; n < 24; n++) begin
      ia = $urandom_range(0, 7);
      ib = $urandom_range(0, 7);
      da = $urandom_range(0, 3);
      db = $urandom_range(0, 3);
      wa = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      sa = wa ? 4'($urandom_range(1, 15)) : 4'hf;
      sb = wb ? 4'($urandom_range(1, 15)) : 4'hf;
      fork
        apply_stimulus(0, wa, sa, 32'h40 + 4 * ia, $urandom, da, ra);
        apply_stimulus(1, wb, sb, 32'h40 + 4 * ib, $urandom, db, rb);
      join
    end

    repeat (4) @(negedge wb_clk);
    check_output("exp_drained", exp_q.size(), 0);
    check_output("req_drained", a_q.size() + b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master Wishbone-classic arbiter sharing one downstream memory port (x bus) between masters A and B, with fixed priority to A and no preemption of an in-flight cycle. It sits between two bus masters (e.g. CPU instruction/data or CPU/DMA) and a single-port RAM (`sp_ram`) or other slave. Idle outputs are driven to zero so unused buses read as all-zero.

## Interface
- `WIDTH`, default 32: address and data width of all three buses.
- `wb_clk`  in  1: clock, all logic on rising edge.
- `wb_rst_n`  in  1: reset, asynchronous, active-low.
- `a_cyc`, `a_we`  in  1: master A cycle request / write enable.
- `a_sel`  in  4: A byte lane enables.
- `a_adr`, `a_dat`  in  WIDTH: A byte address / write data.
- `a_ack`  out  1: A cycle complete.
- `a_rdt`  out  WIDTH: A read data.
- `b_cyc`, `b_we`, `b_sel`, `b_adr`, `b_dat`, `b_ack`, `b_rdt`: identical set for master B.
- `x_cyc`, `x_we`  out  1: downstream request / write enable.
- `x_sel`  out  4; `x_adr`, `x_dat`  out  WIDTH: downstream lanes, address, write data.
- `x_ack`  in  1; `x_rdt`  in  WIDTH: downstream ack and read data.

## Operation
- Registered owner state: IDLE, OWN_A, OWN_B. Reset -> IDLE.
- Effective grant (combinational): OWN_A -> A; OWN_B -> B; IDLE -> A if `a_cyc`, else B if `b_cyc`, else none.
- Transitions: IDLE with grant A/B and `x_ack`=0 -> OWN_A/OWN_B. Any state with `x_ack`=1 -> IDLE. Otherwise hold.
- Granted master's `cyc/we/sel/adr/dat` are forwarded to x bus. With no grant, all x outputs are 0.
- `a_ack = x_ack & grant==A`, `a_rdt = grant==A ? x_rdt : 0`; B likewise. A non-granted master sees ack 0 and rdt 0.
- Simultaneous requests: A is served first and B waits with `b_cyc` held. B is served in the cycle after A's ack.
- No preemption: a B cycle already owning the bus completes before A, even if A requests mid-cycle.
- Same-address conflicts resolve in service order. A write then B write leaves B's data. A read with a simultaneous B write returns the old data.
- Masters must hold request signals stable until ack and drop `cyc` on the edge after ack.
- Reset mid-cycle: owner returns to IDLE immediately; a pending ack is lost and the master must reissue.

## Timing
- Request to x bus: 0 cycles (combinational) when IDLE.
- Ack and read data paths: combinational x -> granted master.
- Arbiter adds no wait states. Total latency equals slave latency, plus the other master's cycle if the bus is busy.
- After ack, x outputs return to 0 on the following cycle if no other request is pending.

## Structure
- Shared package holds owner-state enum (IDLE/OWN_A/OWN_B) and the `WIDTH` default.
- Companion sub-module `sp_ram`:
  - Parameter `WORDS` (default 512); ports `ck`, `cyc`, `we`, `sel`[4], `addr`, `wdata`, `rdata`.
  - Word index is `addr[$clog2(WORDS)+1:2]`.
  - On a clock edge with `cyc & we`, writes only the bytes enabled by `sel`.
  - `rdata` is registered: `mem[idx]` when `cyc & !we`, else 0.
  - No memory reset; `rdata` resets to 0.
- The ack generator (ack one cycle after `cyc`) lives in the slave wrapper, not in the arbiter.

## Test plan
- A writes 0x12343456 to 0x20, then B writes 0xcafecafe to 0x10. While each cycle is in flight, x bus mirrors the request until ack; afterwards all x outputs are 0. Reads from both masters return the written data.
- A and B write together, 0x12341234@0x00 and 0xabcdabcd@0x04: A is acked first, B next, and both values read back. Writing both to 0x08 leaves 0xabcdabcd.
- B issues a write one or two cycles before A: B completes first without preemption, and both values read back.
- Overlapping reads at offsets −2/−1/0/+1/+2 cycles: each master gets its own data (0x00000000, 0x11111111, 0x22222222, 0x44444444). `a_rdt`/`b_rdt` are 0 whenever that master's `cyc` is low.
- A reads 0x14 (holds 0xfaceface) while B writes 0x12345678 there: A gets 0xfaceface, and a re-read gets 0x12345678.
- Byte lanes: sel 0001 `ab`, 0010 `cd`, 0100 `fe`, 1000 `ca` -> 0xcafecdab. Halfword sel 0011/1100 -> 0xabcd1234.
